// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory-backed responder: one registered address phase per transfer,
// programmable wait states and a two-cycle ERROR response, built on byte-lane RAMs.

module ahb_lite_mem_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  // Contents are deliberately not reset: memory survives HRESETn.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

module ahb_lite_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_BYTES   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int DEPTH     = MEM_BYTES / NUM_LANES;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic                 write;
    logic [NUM_LANES-1:0] lanes;
  } req_t;

  state_t                state;
  req_t                  req;
  logic [3:0]            cnt;
  logic                  rdy_q, resp_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  can_accept, accept, size_err, misalign, range_err, acc_err;
  logic [NUM_LANES-1:0]  lane_mask;
  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic                  unused_ok;

  assign offset     = HADDR - BASE_ADDR;
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = HSEL && HREADY && HTRANS[1] && can_accept;
  assign size_err   = (HSIZE > 3'b010);
  assign misalign   = ((HSIZE == 3'b001) && HADDR[0]) ||
                      ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign range_err  = (offset >= MEM_LIMIT);
  assign acc_err    = size_err || misalign || range_err;

  always_comb begin
    lane_mask = '0;
    case (HSIZE)
      3'b000:  lane_mask = NUM_LANES'(1) << offset[1:0];
      3'b001:  lane_mask = NUM_LANES'(3) << {offset[1], 1'b0};
      default: lane_mask = '1;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      req    <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b1;
      resp_q <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt <= 4'd1) begin
            state <= S_DATA;
            cnt   <= '0;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          rdy_q  <= 1'b1;
          resp_q <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with HREADYOUT=1, so a new address may land here.
          if (accept && acc_err) begin
            state  <= S_ERR1;
            rdy_q  <= 1'b0;
            resp_q <= 1'b1;
          end else if (accept) begin
            req    <= '{idx: offset[IDX_W+1:2], write: HWRITE, lanes: lane_mask};
            resp_q <= 1'b0;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              cnt   <= WS;
              rdy_q <= 1'b0;
            end else begin
              state <= S_DATA;
              rdy_q <= 1'b1;
            end
          end else begin
            state  <= S_IDLE;
            rdy_q  <= 1'b1;
            resp_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Writes commit on the edge closing DATA, so a back-to-back read sees new data.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ahb_lite_mem_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk   (HCLK),
      .we    ((state == S_DATA) && req.write && req.lanes[i]),
      .idx   (req.idx),
      .wdata (HWDATA[8*i +: 8]),
      .rdata (rd_lanes[i])
    );
  end

  assign HREADYOUT = rdy_q;
  assign HRESP     = resp_q;
  assign HRDATA    = ((state == S_DATA) && !req.write) ? DATA_WIDTH'(rd_lanes) : '0;

  assign unused_ok = &{1'b0, HBURST, HTRANS[0]};
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench: pipelined vector table on a zero-wait slave, plus hand
// sequences for wait states, errors and reset on a two-wait-state slave.

module tb_ahb_lite_mem_slave;
  logic        HCLK, HRESETn;
  logic        sel0, sel2;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic        rdy0, resp0, rdy2, resp2;
  logic [31:0] rd0, rd2;

  int passed = 0;
  int total  = 0;

  ahb_lite_mem_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

  ahb_lite_mem_slave #(.WAIT_STATES(2)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(rdy2),
    .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rd2));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        resp;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic rdy, logic resp, logic [31:0] rd);
    vec_t v;
    v = '{sel, trans, wr, size, addr, wdata, rdy, resp, rd};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr; HWDATA = wdata;
  endtask

  // Counts HREADYOUT-low cycles on the wait-state slave until the phase completes.
  task automatic wait_phase(output int lows, output logic [31:0] rd, output logic resp);
    lows = 0; rd = '0; resp = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if (rdy2) begin
        rd = rd2; resp = resp2;
        return;
      end
      lows++;
    end
    lows = 99;
  endtask

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BAD = 3'b011;

  initial begin
    int lows;
    logic [31:0] rd;
    logic resp;

    HRESETn = 1'b0; sel0 = 1'b0; sel2 = 1'b0; HBURST = 3'b011;
    drive(IDL, 1'b0, W, 32'h0, 32'h0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    chk("reset_rdy0", 32'(rdy0), 32'd1);
    chk("reset_resp0", 32'(resp0), 32'd0);
    chk("reset_rd0", rd0, 32'd0);
    chk("reset_rdy2", 32'(rdy2), 32'd1);
    chk("reset_resp2", 32'(resp2), 32'd0);
    chk("reset_rd2", rd2, 32'd0);

    // Each row: address phase driven this cycle, expected outputs of the
    // data phase belonging to the previous row.
    vt.push_back(mk(1, NSQ, 1, W, 32'h010, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, NSQ, 0, W, 32'h010, 32'hDEADBEEF, 1, 0, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF));
    vt.push_back(mk(1, NSQ, 1, W, 32'h100, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, SQ,  1, W, 32'h104, 32'h1,        1, 0, 32'h0));
    vt.push_back(mk(1, BSY, 1, W, 32'h108, 32'h2,        1, 0, 32'h0));
    vt.push_back(mk(1, SQ,  1, W, 32'h108, 32'hFFFFFFFF, 1, 0, 32'h0));
    vt.push_back(mk(1, SQ,  1, W, 32'h10C, 32'h3,        1, 0, 32'h0));
    vt.push_back(mk(1, NSQ, 0, W, 32'h100, 32'h4,        1, 0, 32'h0));
    vt.push_back(mk(1, SQ,  0, W, 32'h104, 32'h0,        1, 0, 32'h1));
    vt.push_back(mk(1, SQ,  0, W, 32'h108, 32'h0,        1, 0, 32'h2));
    vt.push_back(mk(1, SQ,  0, W, 32'h10C, 32'h0,        1, 0, 32'h3));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        1, 0, 32'h4));
    vt.push_back(mk(1, NSQ, 1, W, 32'h040, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, NSQ, 1, B, 32'h041, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, NSQ, 1, H, 32'h042, 32'h1234AA56, 1, 0, 32'h0));
    vt.push_back(mk(1, NSQ, 0, W, 32'h040, 32'hBBCC9999, 1, 0, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        1, 0, 32'hBBCCAA00));
    vt.push_back(mk(1, NSQ, 0, W, 32'h400, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        0, 1, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        1, 1, 32'h0));
    vt.push_back(mk(1, NSQ, 1, W, 32'h000, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, NSQ, 1, H, 32'h003, 32'h11223344, 1, 0, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'hFFFFFFFF, 0, 1, 32'h0));
    vt.push_back(mk(1, NSQ, 1, BAD, 32'h000, 32'h0,      1, 1, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'hFFFFFFFF, 0, 1, 32'h0));
    vt.push_back(mk(1, NSQ, 0, W, 32'h000, 32'h0,        1, 1, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        1, 0, 32'h11223344));
    vt.push_back(mk(0, NSQ, 1, W, 32'h000, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, NSQ, 0, W, 32'h000, 32'h0,        1, 0, 32'h0));
    vt.push_back(mk(1, IDL, 0, W, 32'h0,   32'h0,        1, 0, 32'h11223344));

    @(posedge HCLK); #1;
    foreach (vt[i]) begin
      sel0 = vt[i].sel;
      drive(vt[i].trans, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata);
      @(negedge HCLK);
      chk($sformatf("vec%0d_rdy", i), 32'(rdy0), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_resp", i), 32'(resp0), 32'(vt[i].resp));
      chk($sformatf("vec%0d_rdata", i), rd0, vt[i].rd);
      @(posedge HCLK); #1;
    end

    // Two-wait-state slave: write then read 0x020, next address held during waits.
    sel0 = 1'b0; sel2 = 1'b1;
    drive(NSQ, 1'b1, W, 32'h020, 32'h0);
    @(posedge HCLK); #1;
    drive(NSQ, 1'b0, W, 32'h020, 32'hCAFEF00D);
    wait_phase(lows, rd, resp);
    chk("ws_wr_lows", 32'(lows), 32'd2);
    chk("ws_wr_resp", 32'(resp), 32'd0);
    chk("ws_wr_rdata", rd, 32'd0);
    @(posedge HCLK); #1;
    drive(IDL, 1'b0, W, 32'h0, 32'h0);
    wait_phase(lows, rd, resp);
    chk("ws_rd_lows", 32'(lows), 32'd2);
    chk("ws_rd_resp", 32'(resp), 32'd0);
    chk("ws_rd_rdata", rd, 32'hCAFEF00D);

    // Error on the wait-state slave: no wait states, ERR1 then ERR2.
    @(posedge HCLK); #1;
    drive(NSQ, 1'b0, W, 32'h400, 32'h0);
    @(posedge HCLK); #1;
    drive(IDL, 1'b0, W, 32'h0, 32'h0);
    @(negedge HCLK);
    chk("ws_err1_rdy", 32'(rdy2), 32'd0);
    chk("ws_err1_resp", 32'(resp2), 32'd1);
    @(negedge HCLK);
    chk("ws_err2_rdy", 32'(rdy2), 32'd1);
    chk("ws_err2_resp", 32'(resp2), 32'd1);

    // Reset in the middle of a write's wait states drops the write.
    @(posedge HCLK); #1;
    drive(NSQ, 1'b1, W, 32'h020, 32'h0);
    @(posedge HCLK); #1;
    drive(IDL, 1'b0, W, 32'h0, 32'h55555555);
    @(negedge HCLK);
    chk("rst_pre_rdy", 32'(rdy2), 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(rdy2), 32'd1);
    chk("rst_mid_resp", 32'(resp2), 32'd0);
    chk("rst_mid_rdata", rd2, 32'd0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    drive(NSQ, 1'b0, W, 32'h020, 32'h0);
    @(posedge HCLK); #1;
    drive(IDL, 1'b0, W, 32'h0, 32'h0);
    wait_phase(lows, rd, resp);
    chk("rst_after_lows", 32'(lows), 32'd2);
    chk("rst_after_rdata", rd, 32'hCAFEF00D);

    sel2 = 1'b0;
    @(posedge HCLK); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
